// File: rtl/ex_redirect_ctrl.sv
// EX-stage redirect controller: turns taken branches / jumps into a flush plus a held PC redirect to IF.
// Optional performance counters are built only when REDIRECT_PERF_EN is defined.
module ex_redirect_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_target,
  input  logic        if_redirect_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        stall_ex,
  output logic        misalign_err,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_branch_cnt
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_need;
  logic [31:0] w_eff_target;
  logic        w_misaligned;
  logic        w_handshake;
  logic [31:0] r_redirect_pc;
  logic        r_misalign_err;

  assign w_need = ex_valid & (((ex_opcode == OP_BRANCH) & ex_branch_taken) |
                              (ex_opcode == OP_JAL) | (ex_opcode == OP_JALR));

  // jalr discards bit0 of its sum; B/JAL targets are even by construction
  assign w_eff_target = (ex_opcode == OP_JALR) ? {ex_target[31:1], 1'b0} : ex_target;
  assign w_misaligned = w_eff_target[1];
  assign w_handshake  = (r_state == PEND) & if_redirect_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_need && !w_misaligned) w_next_state = PEND;
      PEND: if (w_handshake) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Flushes are masked during reset since IDLE would otherwise follow the raw EX inputs
  always_comb begin
    redirect_valid = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    stall_ex       = 1'b0;
    case (r_state)
      IDLE: begin
        flush_if_id = w_need & rst_n;
        flush_id_ex = w_need & rst_n;
      end
      PEND: begin
        redirect_valid = 1'b1;
        stall_ex       = 1'b1;
        flush_if_id    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_pc  <= 32'h0;
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= (r_state == IDLE) & w_need & w_misaligned;
      if ((r_state == IDLE) && w_need) begin
        r_redirect_pc <= w_eff_target;
      end
    end
  end

  assign redirect_pc  = r_redirect_pc;
  assign misalign_err = r_misalign_err;

`ifdef REDIRECT_PERF_EN
  logic [31:0] r_perf_redirect_cnt;
  logic [31:0] r_perf_branch_cnt;
  logic        w_branch_seen;

  assign w_branch_seen = (r_state == IDLE) & ex_valid & (ex_opcode == OP_BRANCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_redirect_cnt <= 32'h0;
      r_perf_branch_cnt   <= 32'h0;
    end else begin
      if (w_handshake && (r_perf_redirect_cnt != 32'hFFFF_FFFF)) begin
        r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
      end
      if (w_branch_seen && (r_perf_branch_cnt != 32'hFFFF_FFFF)) begin
        r_perf_branch_cnt <= r_perf_branch_cnt + 32'd1;
      end
    end
  end

  assign perf_redirect_cnt = r_perf_redirect_cnt;
  assign perf_branch_cnt   = r_perf_branch_cnt;
`else
  assign perf_redirect_cnt = 32'h0;
  assign perf_branch_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// Directed bench for ex_redirect_ctrl: a transaction-level model checked every cycle plus literal pins.
module tb_ex_redirect_ctrl;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic        ex_branch_taken;
  logic [31:0] ex_target;
  logic        if_redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        stall_ex;
  logic        misalign_err;
  logic [31:0] perf_redirect_cnt;
  logic [31:0] perf_branch_cnt;

  int errors = 0;
  int checks = 0;

  // Model: outstanding redirect targets, pending misalign pulse, event counts
  logic [31:0] m_q[$];
  logic        m_mis;
  logic [31:0] m_rcnt;
  logic [31:0] m_bcnt;

  ex_redirect_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid          (ex_valid),
    .ex_opcode         (ex_opcode),
    .ex_branch_taken   (ex_branch_taken),
    .ex_target         (ex_target),
    .if_redirect_ready (if_redirect_ready),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .flush_if_id       (flush_if_id),
    .flush_id_ex       (flush_id_ex),
    .stall_ex          (stall_ex),
    .misalign_err      (misalign_err),
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_branch_cnt   (perf_branch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_mis  = 1'b0;
    m_rcnt = 32'h0;
    m_bcnt = 32'h0;
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef REDIRECT_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Compare at the negedge, then advance the model across the following posedge
  task automatic tick();
    logic        need;
    logic        pend;
    logic [31:0] eff;
    @(negedge clk);
    pend = (m_q.size() != 0);
    eff  = ex_target;
    if (ex_opcode == OP_JALR) eff[0] = 1'b0;
    need = ex_valid && ((ex_opcode == OP_BR && ex_branch_taken) ||
                        ex_opcode == OP_JAL || ex_opcode == OP_JALR);
    if (!rst_n) begin
      chk("rst redirect_valid", {31'b0, redirect_valid}, 32'h0);
      chk("rst flush_if_id", {31'b0, flush_if_id}, 32'h0);
      chk("rst flush_id_ex", {31'b0, flush_id_ex}, 32'h0);
      chk("rst stall_ex", {31'b0, stall_ex}, 32'h0);
      chk("rst misalign_err", {31'b0, misalign_err}, 32'h0);
      chk("rst redirect_pc", redirect_pc, 32'h0);
      chk("rst perf_redirect_cnt", perf_redirect_cnt, 32'h0);
      chk("rst perf_branch_cnt", perf_branch_cnt, 32'h0);
    end else begin
      chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, pend});
      chk("stall_ex", {31'b0, stall_ex}, {31'b0, pend});
      chk("flush_if_id", {31'b0, flush_if_id}, {31'b0, pend | need});
      chk("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, !pend && need});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
      if (pend) chk("redirect_pc", redirect_pc, m_q[0]);
      chk("perf_redirect_cnt", perf_redirect_cnt, exp_cnt(m_rcnt));
      chk("perf_branch_cnt", perf_branch_cnt, exp_cnt(m_bcnt));
    end
    @(posedge clk);
    if (rst_n) begin
      if (pend) begin
        m_mis = 1'b0;
        if (if_redirect_ready) begin
          void'(m_q.pop_front());
          if (m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 32'd1;
        end
      end else begin
        m_mis = need && eff[1];
        if (need && !eff[1]) m_q.push_back(eff);
        if (ex_valid && ex_opcode == OP_BR && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic tk,
                       input logic [31:0] tgt, input logic rdy);
    ex_valid          = v;
    ex_opcode         = op;
    ex_branch_taken   = tk;
    ex_target         = tgt;
    if_redirect_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int hi_cycles;
    model_clear();
    rst_n = 1'b0;
    drive(1'b1, OP_JAL, 1'b0, 32'h0000_0400, 1'b1);
    #2;
    chk("reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("reset flush_if_id", {31'b0, flush_if_id}, 32'h0);
    chk("reset redirect_pc", redirect_pc, 32'h0);
    tick();
    do_reset();

    // Taken BEQ -> one-cycle-later redirect
    drive(1'b1, OP_BR, 1'b1, 32'h0000_0100, 1'b1);
    #1;
    chk("beq c0 flush_if_id", {31'b0, flush_if_id}, 32'h1);
    chk("beq c0 flush_id_ex", {31'b0, flush_id_ex}, 32'h1);
    chk("beq c0 redirect_valid", {31'b0, redirect_valid}, 32'h0);
    tick();
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b1);
    #1;
    chk("beq c1 redirect_valid", {31'b0, redirect_valid}, 32'h1);
    chk("beq c1 redirect_pc", redirect_pc, 32'h0000_0100);
    chk("beq c1 flush_id_ex", {31'b0, flush_id_ex}, 32'h0);
    tick();
    chk("beq c2 redirect_valid", {31'b0, redirect_valid}, 32'h0);
    tick();

    // Misaligned JALR
    drive(1'b1, OP_JALR, 1'b0, 32'h0000_2003, 1'b1);
    #1;
    chk("jalr mis c0 flush_id_ex", {31'b0, flush_id_ex}, 32'h1);
    tick();
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b1);
    #1;
    chk("jalr mis c1 misalign_err", {31'b0, misalign_err}, 32'h1);
    chk("jalr mis c1 redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("jalr mis c1 redirect_pc", redirect_pc, 32'h0000_2002);
    tick();
    chk("jalr mis c2 misalign_err", {31'b0, misalign_err}, 32'h0);
    chk("jalr mis c2 redirect_valid", {31'b0, redirect_valid}, 32'h0);
    tick();

    // Aligned JALR clears bit0 only
    drive(1'b1, OP_JALR, 1'b0, 32'h0000_3005, 1'b1);
    tick();
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b1);
    #1;
    chk("jalr ok redirect_pc", redirect_pc, 32'h0000_3004);
    tick();
    tick();

    // JAL held off by IF for 5 cycles; EX inputs in PEND must be ignored
    drive(1'b1, OP_JAL, 1'b0, 32'h0000_0040, 1'b0);
    tick();
    drive(1'b1, OP_BR, 1'b1, 32'h0000_0999, 1'b0);
    hi_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) if_redirect_ready = 1'b1;
      #1;
      if (redirect_valid && stall_ex) hi_cycles++;
      chk("jal hold redirect_pc", redirect_pc, 32'h0000_0040);
      tick();
    end
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b1);
    chk("jal hold cycles", hi_cycles, 32'd6);
    #1;
    chk("jal hold released", {31'b0, redirect_valid}, 32'h0);
    tick();

    // Not-taken BNE then ADDI: no redirect, branch counted once
    do_reset();
    drive(1'b1, OP_BR, 1'b0, 32'h0000_0200, 1'b1);
    #1;
    chk("bne nt flush_if_id", {31'b0, flush_if_id}, 32'h0);
    tick();
    drive(1'b1, OP_ADDI, 1'b1, 32'h0000_0300, 1'b1);
    #1;
    chk("addi flush_id_ex", {31'b0, flush_id_ex}, 32'h0);
    tick();
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b1);
    #1;
    chk("bne redirect_valid", {31'b0, redirect_valid}, 32'h0);
`ifdef REDIRECT_PERF_EN
    chk("bne perf_branch_cnt", perf_branch_cnt, 32'd1);
`else
    chk("bne perf_branch_cnt", perf_branch_cnt, 32'd0);
`endif
    chk("bne perf_redirect_cnt", perf_redirect_cnt, 32'd0);
    tick();

    // Reset asserted while PEND
    drive(1'b1, OP_JAL, 1'b0, 32'h0000_0300, 1'b0);
    tick();
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b0);
    #1;
    chk("pre-rst redirect_valid", {31'b0, redirect_valid}, 32'h1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("mid-pend rst redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("mid-pend rst stall_ex", {31'b0, stall_ex}, 32'h0);
    chk("mid-pend rst perf_branch_cnt", perf_branch_cnt, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, OP_JAL, 1'b0, 32'h0000_0080, 1'b1);
    tick();
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b1);
    #1;
    chk("post-rst redirect_valid", {31'b0, redirect_valid}, 32'h1);
    chk("post-rst redirect_pc", redirect_pc, 32'h0000_0080);
    tick();

    // Two JALs spaced by one cycle
    do_reset();
    drive(1'b1, OP_JAL, 1'b0, 32'h0000_0010, 1'b1);
    tick();
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b1, OP_JAL, 1'b0, 32'h0000_0020, 1'b1);
    tick();
    drive(1'b0, OP_ADDI, 1'b0, 32'h0, 1'b1);
    #1;
    chk("jal2 redirect_pc", redirect_pc, 32'h0000_0020);
    tick();
    tick();
`ifdef REDIRECT_PERF_EN
    chk("jal2 perf_redirect_cnt", perf_redirect_cnt, 32'd2);
`else
    chk("jal2 perf_redirect_cnt", perf_redirect_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
